// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath with a retired-instruction counter.
// Define BNE_EN to add bne (Op 000101) as a branch taken on ~Zero.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_write;
    logic             branch;
    logic             taken;
    logic             retire;

    function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
        case (f)
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        PCSrc      = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        taken      = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_to_alu(Funct);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
`ifdef BNE_EN
                taken      = (Op == OP_BNE) ? ~Zero : Zero;
`else
                taken      = Zero;
`endif
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Retiring states all return to FETCH, so a retire pulse marks exactly one completed instruction.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    assign PCEn        = pc_write | (branch & taken);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectation table plus async-reset and counter-wrap sequences.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;

    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instr_count;

    logic        b_IorD, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA, b_PCEn, b_illegal;
    logic [1:0]  b_ALUSrcB, b_PCSrc;
    logic [2:0]  b_ALUControl;
    logic [1:0]  b_instr_count;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .illegal(illegal),
        .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(b_IorD), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegDst(b_RegDst),
        .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .ALUControl(b_ALUControl), .PCSrc(b_PCSrc), .PCEn(b_PCEn), .illegal(b_illegal),
        .instr_count(b_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] act;
    assign act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, PCEn, illegal};

    function automatic logic [15:0] ex(input logic iord, input logic memw, input logic irw,
                                       input logic regdst, input logic m2r, input logic regw,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [2:0] aluc, input logic [1:0] pcsrc,
                                       input logic pcen, input logic ill);
        return {iord, memw, irw, regdst, m2r, regw, srca, srcb, aluc, pcsrc, pcen, ill};
    endfunction

    localparam logic [5:0] XOP = 6'b110011;
    localparam logic [5:0] XFN = 6'b011110;

    logic [15:0] E_F, E_D, E_DILL, E_MA, E_MRD, E_MWB, E_MWR, E_AWB, E_AEX, E_AIWB, E_J;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [15:0] exp;
        int unsigned cnt;
        string       tag;
    } vec_t;

    vec_t        vecs[$];
    int unsigned run_cnt;

    task automatic add(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input logic [15:0] exp, input string tag);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.exp = exp; v.cnt = run_cnt; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic chk_out(input string name, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s outputs got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [31:0] exp);
        checks++;
        if (instr_count !== exp) begin
            errors++;
            $display("FAIL %s instr_count got %0d want %0d", name, instr_count, exp);
        end
    endtask

    task automatic chk_cnt2(input string name, input logic [1:0] exp);
        checks++;
        if (b_instr_count !== exp) begin
            errors++;
            $display("FAIL %s instr_count(CNT_W=2) got %0d want %0d", name, b_instr_count, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                        input logic [15:0] exp, input string name);
        Op = op; Funct = funct; Zero = zero;
        #2;
        chk_out(name, exp);
    endtask

    initial begin
        E_F    = ex(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
        E_D    = ex(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
        E_DILL = ex(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
        E_MA   = ex(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        E_MRD  = ex(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        E_MWB  = ex(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0);
        E_MWR  = ex(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        E_AWB  = ex(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0);
        E_AEX  = ex(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        E_AIWB = ex(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0);
        E_J    = ex(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0);

        run_cnt = 0;
        // lw: Op garbage outside DECODE/MEMADR must not matter
        add(XOP, XFN, 1, E_F, "lw fetch");
        add(6'b100011, XFN, 1, E_D, "lw decode");
        add(6'b100011, XFN, 1, E_MA, "lw memadr");
        add(XOP, XFN, 1, E_MRD, "lw memrd");
        add(XOP, XFN, 1, E_MWB, "lw memwb");
        run_cnt++;
        add(XOP, XFN, 1, E_F, "sw fetch");
        add(6'b101011, XFN, 1, E_D, "sw decode");
        add(6'b101011, XFN, 1, E_MA, "sw memadr");
        add(XOP, XFN, 1, E_MWR, "sw memwr");
        run_cnt++;
        begin
            logic [5:0] fn [5];
            logic [2:0] al [5];
            fn = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b000000};
            al = '{3'b111, 3'b110, 3'b000, 3'b001, 3'b010};
            for (int k = 0; k < 5; k++) begin
                add(XOP, XFN, 1, E_F, "rtype fetch");
                add(6'b000000, XFN, 1, E_D, "rtype decode");
                add(XOP, fn[k], 1, ex(0,0,0,0,0,0,1,2'b00,al[k],2'b00,0,0), "rtype execute");
                add(XOP, XFN, 1, E_AWB, "rtype aluwb");
                run_cnt++;
            end
        end
        add(XOP, XFN, 1, E_F, "addi fetch");
        add(6'b001000, XFN, 1, E_D, "addi decode");
        add(XOP, XFN, 1, E_AEX, "addi exec");
        add(XOP, XFN, 1, E_AIWB, "addi wb");
        run_cnt++;
        add(XOP, XFN, 0, E_F, "beq taken fetch");
        add(6'b000100, XFN, 0, E_D, "beq taken decode");
        add(6'b000100, XFN, 1, ex(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0), "beq taken branch");
        run_cnt++;
        add(XOP, XFN, 1, E_F, "beq not-taken fetch");
        add(6'b000100, XFN, 1, E_D, "beq not-taken decode");
        add(6'b000100, XFN, 0, ex(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0), "beq not-taken branch");
        run_cnt++;
`ifdef BNE_EN
        add(XOP, XFN, 1, E_F, "bne fetch");
        add(6'b000101, XFN, 1, E_D, "bne decode");
        add(6'b000101, XFN, 0, ex(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0), "bne branch");
        run_cnt++;
`else
        add(XOP, XFN, 1, E_F, "bne-off fetch");
        add(6'b000101, XFN, 1, E_DILL, "bne-off decode illegal");
`endif
        add(XOP, XFN, 1, E_F, "illegal fetch");
        add(6'b111111, XFN, 1, E_DILL, "illegal decode");
        add(XOP, XFN, 1, E_F, "j fetch");
        add(6'b000010, XFN, 1, E_D, "j decode");
        add(XOP, XFN, 0, E_J, "j jump");
        run_cnt++;

        // Reset state, checked while reset is held
        reset = 1'b1; Op = XOP; Funct = XFN; Zero = 1'b0;
        #2;
        chk_out("reset fetch outputs", E_F);
        chk_cnt("reset count", 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].exp, vecs[i].tag);
            chk_cnt(vecs[i].tag, vecs[i].cnt);
            @(posedge clk);
            #1;
        end

        // Async reset in the middle of a lw (during MEMRD)
        step(6'b100011, XFN, 1, E_F, "mid-reset lw fetch");
        chk_cnt("count after table", run_cnt);
        @(posedge clk); #1;
        step(6'b100011, XFN, 1, E_D, "mid-reset lw decode");
        @(posedge clk); #1;
        step(6'b100011, XFN, 1, E_MA, "mid-reset lw memadr");
        @(posedge clk); #1;
        step(XOP, XFN, 1, E_MRD, "mid-reset lw memrd");
        #1 reset = 1'b1;
        #1;
        chk_out("async reset outputs", E_F);
        chk_cnt("async reset count", 32'd0);
        chk_cnt2("async reset count", 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Five jumps: the 2-bit counter wraps 3 -> 0 -> 1
        for (int k = 0; k < 5; k++) begin
            step(XOP, XFN, 1, E_F, "wrap j fetch");
            chk_cnt("wrap count", k);
            chk_cnt2("wrap count", 2'(k));
            @(posedge clk); #1;
            step(6'b000010, XFN, 1, E_D, "wrap j decode");
            @(posedge clk); #1;
            step(XOP, XFN, 1, E_J, "wrap j jump");
            @(posedge clk); #1;
        end
        step(XOP, XFN, 1, E_F, "wrap final fetch");
        chk_cnt("wrap final count", 32'd5);
        chk_cnt2("wrap final count", 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
